pipelined_ripple_adder: RTL and testbench
=========================================

Name: pipelined_ripple_adder

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry adder.
- The operand width is split into CHUNK_WIDTH-bit chunks. Each pipeline stage adds one chunk and registers the carry for the next stage.
- Adds add/subtract mode, signed overflow and a valid/ready handshake with back-pressure.
- Used as the arithmetic element in datapaths that need a full-width add at high fmax with one result per cycle.

Parameters:
- DATA_WIDTH, 16, operand/result width; must be a multiple of CHUNK_WIDTH.
- CHUNK_WIDTH, 4, bits added per pipeline stage.
- STAGES, DATA_WIDTH/CHUNK_WIDTH (derived, not overridable), pipeline depth.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- din_a  in  DATA_WIDTH  operand a.
- din_b  in  DATA_WIDTH  operand b.
- din_ci  in  1  carry-in (add mode only).
- din_sub  in  1  1: compute a - b; 0: compute a + b + ci.
- din_vld  in  1  input transaction valid.
- din_rd  out  1  input ready.
- dout_s  out  DATA_WIDTH  sum/difference.
- dout_co  out  1  carry-out; in sub mode 1 = no borrow.
- dout_ovf  out  1  two's-complement signed overflow.
- dout_vld  out  1  output valid.
- dout_rd  in  1  output ready.

Behaviour:
- Handshake: a transfer occurs when vld & rd are both high on a clk edge. dout_* is held stable while dout_vld=1 & dout_rd=0.
- Operand conditioning at input: b_eff = din_sub ? ~din_b : din_b; c_in = din_sub ? 1 : din_ci. din_ci is ignored when din_sub=1.
- Stage k (0..STAGES-1) holds the following registers:
  - valid bit;
  - carry;
  - result chunks 0..k (already computed);
  - operand chunks k+1..STAGES-1 (not yet consumed).
- Stage k computes chunk k as chunk_a + chunk_b_eff + carry, in CHUNK_WIDTH+1 bits.
- The last stage also captures the carry into the MSB, for overflow.
- dout_ovf = carry_into_msb ^ carry_out. dout_co = carry out of the MSB.
- Latency: STAGES cycles from input transfer to dout_vld with no stall (4 for the defaults).
- Throughput: 1 transaction/cycle when dout_rd is held at 1.
- Stall rule: stage k advances when valid[k]=1 and (stage k+1 is empty, or stage k+1 advances). The last stage advances on the dout handshake.
- din_rd = !valid[0] | advance[0]. The ready chain is combinational. Bubbles collapse: an empty stage accepts regardless of downstream.
- Stalled stages hold all their registers unchanged.
- Simultaneous accept and release in the same stage in one cycle is legal and loses no data.
- Reset (async assert, rst_n=0):
  - all valid bits = 0, so dout_vld = 0 and din_rd = 1 after reset;
  - dout_s = 0, dout_co = 0, dout_ovf = 0;
  - data registers also cleared to 0.
- Reset mid-operation discards all in-flight transactions; nothing is emitted after release.
- Deassertion is taken as synchronised externally.
- Wrap-around: results are modulo 2^DATA_WIDTH; the carry/borrow is reported only on dout_co.
- DATA_WIDTH == CHUNK_WIDTH is legal: single stage, latency 1.

Decomposition:
- Shared package:
  - a compile-time check that DATA_WIDTH % CHUNK_WIDTH == 0;
  - the STAGES derivation;
  - a chunk-slice helper (index → bit range).
- One natural sub-module: adder_chunk.
  - Purely combinational CHUNK_WIDTH-bit ripple adder built from per-bit full-adder equations.
  - Inputs a, b, ci; outputs s, co, plus c_msb_in (carry into its top bit).
  - Instantiated STAGES times in a generate loop.
  - The top level owns all registers and handshake logic.

Test Plan:
- Defaults, add, dout_rd=1: a=0xFFFF, b=0x0001, ci=0 → exactly 4 cycles later dout_vld=1, s=0x0000, co=1, ovf=0. Checks full carry propagation across all chunks.
- Sub mode: a=0x8000, b=0x0001, sub=1 → s=0x7FFF, co=1, ovf=1. Then a=0x0000, b=0x0001, sub=1 → s=0xFFFF, co=0, ovf=0.
- Add overflow: a=0x7FFF, b=0x0001, ci=0 → s=0x8000, co=0, ovf=1. Then a=0x1234, b=0x4321, ci=1 → s=0x5556, co=0, ovf=0.
- Streaming with back-pressure: 20 random transactions, din_vld=1 continuously, dout_rd toggled pseudo-randomly at 50%.
  - Outputs match the reference model in order, with no loss or duplication.
  - dout_* stays stable while stalled.
  - din_rd drops only when all 4 stages are full and dout_rd=0.
- Bubble collapse: issue 1 transaction, hold dout_rd=0 for 10 cycles, issue 3 more → all 4 stages fill, din_rd=0. Raise dout_rd → results emitted on 4 consecutive cycles.
- Reset mid-flight: 3 transactions in flight, pulse rst_n low between clock edges.
  - dout_vld falls immediately (async) and din_rd=1.
  - No stale output appears after release.
  - The next transaction yields the correct result after 4 cycles.

Source files
------------

// File: rtl/pipelined_ripple_adder_pkg.sv
// rtl/pipelined_ripple_adder_pkg.sv - shared sizing helpers for the pipelined ripple adder
package pipelined_ripple_adder_pkg;

    function automatic bit widths_ok(input int data_width, input int chunk_width);
        return (chunk_width > 0) && (data_width >= chunk_width) && (data_width % chunk_width == 0);
    endfunction

    function automatic int calc_stages(input int data_width, input int chunk_width);
        return data_width / chunk_width;
    endfunction

    function automatic int chunk_lo(input int idx, input int chunk_width);
        return idx * chunk_width;
    endfunction

    function automatic int chunk_hi(input int idx, input int chunk_width);
        return idx * chunk_width + chunk_width - 1;
    endfunction

endpackage

// File: rtl/pipelined_ripple_adder_chunk.sv
// rtl/pipelined_ripple_adder_chunk.sv - combinational WIDTH-bit ripple adder from full-adder equations
module adder_chunk
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_ci,
    output logic [WIDTH-1:0] o_s,
    output logic             o_co,
    output logic             o_c_msb_in
);

    logic [WIDTH:0] w_c;

    always_comb begin
        w_c    = '0;
        o_s    = '0;
        w_c[0] = i_ci;
        for (int i = 0; i < WIDTH; i++) begin
            o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
            w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
        end
    end

    assign o_co       = w_c[WIDTH];
    assign o_c_msb_in = w_c[WIDTH-1];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// rtl/pipelined_ripple_adder.sv - chunked, pipelined add/subtract with valid/ready back-pressure
module pipelined_ripple_adder
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int CHUNK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] din_a,
    input  logic [DATA_WIDTH-1:0] din_b,
    input  logic                  din_ci,
    input  logic                  din_sub,
    input  logic                  din_vld,
    output logic                  din_rd,
    output logic [DATA_WIDTH-1:0] dout_s,
    output logic                  dout_co,
    output logic                  dout_ovf,
    output logic                  dout_vld,
    input  logic                  dout_rd
);

    localparam int STAGES = calc_stages(DATA_WIDTH, CHUNK_WIDTH);

    if (!widths_ok(DATA_WIDTH, CHUNK_WIDTH)) begin : g_bad_width
        $error("DATA_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
    end

    logic [DATA_WIDTH-1:0] w_b_eff;
    logic                  w_c_in;
    logic [STAGES-1:0]     w_v;
    logic [STAGES-1:0]     w_adv;
    logic [STAGES-1:0]     w_load;
    logic                  r_cmsb;

    // Subtraction is a + ~b + 1, so the carry-in is forced high and din_ci ignored.
    assign w_b_eff = din_sub ? ~din_b : din_b;
    assign w_c_in  = din_sub | din_ci;

    always_comb begin
        w_adv            = '0;
        w_load           = '0;
        w_adv[STAGES-1]  = w_v[STAGES-1] & dout_rd;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = w_v[k] & (~w_v[k+1] | w_adv[k+1]);
        end
        w_load[0] = din_vld & (~w_v[0] | w_adv[0]);
        for (int k = 1; k < STAGES; k++) begin
            w_load[k] = w_adv[k-1];
        end
    end

    assign din_rd = ~w_v[0] | w_adv[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int LO = chunk_lo(k, CHUNK_WIDTH);
        localparam int RW = DATA_WIDTH - LO;
        localparam int SW = chunk_hi(k, CHUNK_WIDTH) + 1;

        // Stage k keeps result chunks 0..k and only the operand chunks still to be consumed.
        logic [RW-1:0]          w_a_rem;
        logic [RW-1:0]          w_b_rem;
        logic                   w_ci;
        logic [CHUNK_WIDTH-1:0] w_cs;
        logic                   w_co;
        logic                   w_cmsb;
        logic [SW-1:0]          w_sum_nx;
        logic                   r_v;
        logic                   r_c;
        logic [SW-1:0]          r_sum;

        if (k == 0) begin : g_in
            assign w_a_rem  = din_a;
            assign w_b_rem  = w_b_eff;
            assign w_ci     = w_c_in;
            assign w_sum_nx = w_cs;
        end else begin : g_in
            assign w_a_rem  = g_stg[k-1].g_op.r_opa;
            assign w_b_rem  = g_stg[k-1].g_op.r_opb;
            assign w_ci     = g_stg[k-1].r_c;
            assign w_sum_nx = {w_cs, g_stg[k-1].r_sum};
        end

        adder_chunk #(
            .WIDTH (CHUNK_WIDTH)
        ) u_chunk (
            .i_a        (w_a_rem[CHUNK_WIDTH-1:0]),
            .i_b        (w_b_rem[CHUNK_WIDTH-1:0]),
            .i_ci       (w_ci),
            .o_s        (w_cs),
            .o_co       (w_co),
            .o_c_msb_in (w_cmsb)
        );

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
            end else if (w_load[k]) begin
                r_v   <= 1'b1;
                r_c   <= w_co;
                r_sum <= w_sum_nx;
            end else if (w_adv[k]) begin
                r_v   <= 1'b0;
            end
        end

        assign w_v[k] = r_v;

        if (k < STAGES - 1) begin : g_op
            logic [RW-CHUNK_WIDTH-1:0] r_opa;
            logic [RW-CHUNK_WIDTH-1:0] r_opb;
            logic                      w_unused_cmsb;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_opa <= '0;
                    r_opb <= '0;
                end else if (w_load[k]) begin
                    r_opa <= w_a_rem[RW-1:CHUNK_WIDTH];
                    r_opb <= w_b_rem[RW-1:CHUNK_WIDTH];
                end
            end

            assign w_unused_cmsb = w_cmsb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmsb <= 1'b0;
        end else if (w_load[STAGES-1]) begin
            r_cmsb <= g_stg[STAGES-1].w_cmsb;
        end
    end

    assign dout_vld = w_v[STAGES-1];
    assign dout_s   = g_stg[STAGES-1].r_sum;
    assign dout_co  = g_stg[STAGES-1].r_c;
    assign dout_ovf = r_cmsb ^ g_stg[STAGES-1].r_c;

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// tb/tb_pipelined_ripple_adder.sv - self-checking bench for pipelined_ripple_adder
module tb_pipelined_ripple_adder;

    localparam int DW = 16;
    localparam int S  = 4;

    typedef struct packed {
        logic [DW-1:0] s;
        logic          co;
        logic          ovf;
    } res_t;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          ci;
        logic          sub;
        logic [DW-1:0] s;
        logic          co;
        logic          ovf;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din_a = '0;
    logic [DW-1:0] din_b = '0;
    logic          din_ci = 1'b0;
    logic          din_sub = 1'b0;
    logic          din_vld = 1'b0;
    logic          din_rd;
    logic [DW-1:0] dout_s;
    logic          dout_co;
    logic          dout_ovf;
    logic          dout_vld;
    logic          dout_rd = 1'b1;

    int   tests = 0;
    int   fails = 0;
    res_t sb[$];
    bit   rst_evt = 1'b0;
    bit   prev_stall = 1'b0;
    logic [DW+1:0] prev_out = '0;

    pipelined_ripple_adder #(
        .DATA_WIDTH  (DW),
        .CHUNK_WIDTH (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din_a    (din_a),
        .din_b    (din_b),
        .din_ci   (din_ci),
        .din_sub  (din_sub),
        .din_vld  (din_vld),
        .din_rd   (din_rd),
        .dout_s   (dout_s),
        .dout_co  (dout_co),
        .dout_ovf (dout_ovf),
        .dout_vld (dout_vld),
        .dout_rd  (dout_rd)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                   input logic ci, input logic sub);
        res_t        o;
        int          sa = $signed(a);
        int          sbv = $signed(b);
        int          r;
        int unsigned ua = a;
        int unsigned ub = b;
        if (sub) begin
            r    = sa - sbv;
            o.co = (ua >= ub);
            o.s  = DW'(ua - ub);
        end else begin
            r    = sa + sbv + int'(ci);
            o.co = (ua + ub + int'(ci)) > 32'd65535;
            o.s  = DW'(ua + ub + int'(ci));
        end
        o.ovf = (r > 32767) || (r < -32768);
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting, got none, expected handshake", name);
    endtask

    // Called at posedge+1; returns at posedge+1 just after the input transfer edge.
    task automatic send(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci, input logic sub);
        int n = 0;
        din_a = a; din_b = b; din_ci = ci; din_sub = sub; din_vld = 1'b1;
        @(negedge clk);
        while (!din_rd && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!din_rd) timeout("send");
        @(posedge clk);
        #1;
        din_vld = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!dout_vld && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    always @(negedge rst_n) begin
        sb.delete();
        rst_evt = 1'b1;
    end

    // Scoreboard, ready rule and stall-stability checks, sampled mid-cycle.
    always @(negedge clk) begin : mon
        res_t e;
        if (rst_evt) begin
            prev_stall = 1'b0;
            rst_evt    = 1'b0;
        end
        if (rst_n) begin
            check("din_rd_rule", 32'(din_rd), 32'(!(sb.size() == S && !dout_rd)));
            if (prev_stall) begin
                check("stall_vld", 32'(dout_vld), 32'd1);
                check("stall_hold", 32'({dout_s, dout_co, dout_ovf}), 32'(prev_out));
            end
            if (dout_vld && dout_rd) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got s=0x%0h, expected no output", dout_s);
                end else begin
                    e = sb.pop_front();
                    check("out_s", 32'(dout_s), 32'(e.s));
                    check("out_co", 32'(dout_co), 32'(e.co));
                    check("out_ovf", 32'(dout_ovf), 32'(e.ovf));
                end
            end
            if (din_vld && din_rd) sb.push_back(model(din_a, din_b, din_ci, din_sub));
            prev_stall = dout_vld && !dout_rd;
            prev_out   = {dout_s, dout_co, dout_ovf};
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   lat;
        int   sent;
        int   cyc;
        bit   xfer;
        res_t e;
        logic [DW-1:0] ra, rb;
        logic rci, rsub;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[2] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[5] = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", 32'(dout_vld), 32'd0);
        check("rst_din_rd", 32'(din_rd), 32'd1);
        check("rst_s", 32'(dout_s), 32'd0);
        check("rst_co", 32'(dout_co), 32'd0);
        check("rst_ovf", 32'(dout_ovf), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dout_rd = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sub);
            wait_out(lat);
            check("vec_latency", 32'(lat), 32'(S));
            check("vec_s", 32'(dout_s), 32'(vecs[i].s));
            check("vec_co", 32'(dout_co), 32'(vecs[i].co));
            check("vec_ovf", 32'(dout_ovf), 32'(vecs[i].ovf));
            @(posedge clk);
            #1;
        end

        // Bubble collapse: one result parked at the output, three more fill the gaps.
        dout_rd = 1'b0;
        send(16'h00F0, 16'h0F0F, 1'b1, 1'b0);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("bubble_parked_vld", 32'(dout_vld), 32'd1);
        check("bubble_din_rd_open", 32'(din_rd), 32'd1);
        for (int j = 0; j < 3; j++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        check("bubble_full_din_rd", 32'(din_rd), 32'd0);
        dout_rd = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check("bubble_drain_vld", 32'(dout_vld), 32'd1);
            @(posedge clk);
            #1;
        end
        check("bubble_drained", 32'(dout_vld), 32'd0);

        // Random streaming with back-pressure.
        sent = 0;
        cyc  = 0;
        din_a = 16'($urandom); din_b = 16'($urandom);
        din_ci = 1'($urandom); din_sub = 1'($urandom);
        din_vld = 1'b1;
        while (sent < 20 && cyc < 2000) begin
            dout_rd = 1'($urandom_range(0, 1));
            @(negedge clk);
            xfer = din_rd;
            @(posedge clk);
            #1;
            if (xfer) begin
                sent++;
                din_a = 16'($urandom); din_b = 16'($urandom);
                din_ci = 1'($urandom); din_sub = 1'($urandom);
            end
            cyc++;
        end
        din_vld = 1'b0;
        if (sent < 20) timeout("stream_send");
        dout_rd = 1'b1;
        cyc = 0;
        while ((sb.size() != 0 || dout_vld) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("stream_drained", 32'(sb.size()), 32'd0);

        // Reset mid-flight with a result waiting at the output.
        dout_rd = 1'b0;
        for (int j = 0; j < 3; j++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        @(posedge clk);
        #1;
        check("pre_reset_vld", 32'(dout_vld), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_vld", 32'(dout_vld), 32'd0);
        check("async_rst_din_rd", 32'(din_rd), 32'd1);
        check("async_rst_s", 32'(dout_s), 32'd0);
        check("async_rst_co", 32'(dout_co), 32'd0);
        check("async_rst_ovf", 32'(dout_ovf), 32'd0);
        #1;
        rst_n = 1'b1;
        dout_rd = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < 6; j++) begin
            check("no_stale_vld", 32'(dout_vld), 32'd0);
            @(posedge clk);
            #1;
        end
        ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom); rsub = 1'($urandom);
        e = model(ra, rb, rci, rsub);
        send(ra, rb, rci, rsub);
        wait_out(lat);
        check("post_reset_latency", 32'(lat), 32'(S));
        check("post_reset_s", 32'(dout_s), 32'(e.s));
        check("post_reset_co", 32'(dout_co), 32'(e.co));
        check("post_reset_ovf", 32'(dout_ovf), 32'(e.ovf));
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
